// File: rtl/shift_pipe_arbiter.sv
// shift_pipe_arbiter
//   Round-robin arbiter that shares one DEPTH-stage shift pipeline among
//   NREQ requesters. A granted word enters stage 0 together with the index
//   of the requester that produced it. Word and tag move one stage per
//   clock and leave at the last stage after exactly DEPTH cycles.
//
//   Optional feature macro: PIPE_STALL_EN
//     When defined, an out_ready input is added. The pipeline only advances
//     when the last stage is empty or is being consumed. While it is stalled,
//     every stage, the pointer and the inflight count hold, and no grant is
//     issued.
//     When undefined, the pipeline advances every cycle and the output is
//     always consumed.

module shift_pipe_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int TAGW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNTW  = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_data,
`ifdef PIPE_STALL_EN
  input  logic                   out_ready,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAGW-1:0]        out_tag,
  output logic [CNTW-1:0]        inflight
);

  // Rotating priority pointer: the search for a requester starts here
  logic [TAGW-1:0]  r_ptr;

  // Pipeline stages; index 0 is the entry stage, DEPTH-1 is the exit stage
  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];
  logic [TAGW-1:0]  r_tag   [DEPTH];

  // Number of valid stages, kept as a register so it never glitches
  logic [CNTW-1:0]  r_inflight;

  logic             w_advance;
  logic             w_found;
  logic [TAGW-1:0]  w_idx;
  logic [NREQ-1:0]  w_gnt;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;
  logic [TAGW-1:0]  w_ptr_next;
  logic [CNTW-1:0]  w_count_next;

  // Decide whether the pipeline may move this cycle
`ifdef PIPE_STALL_EN
  assign w_advance = !r_valid[DEPTH-1] | out_ready;
`else
  assign w_advance = 1'b1;
`endif

  // Search req starting at r_ptr and wrapping modulo NREQ; the candidate
  // index is one bit wider than the tag so the wrap works for any NREQ
  always_comb begin
    logic [TAGW:0] cand;
    cand    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, r_ptr} + (TAGW+1)'(k);
      if (cand >= (TAGW+1)'(NREQ)) begin
        cand = cand - (TAGW+1)'(NREQ);
      end
      if (!w_found && req[cand[TAGW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = cand[TAGW-1:0];
      end
    end
  end

  // Turn the winning index into a one-hot grant; no grant while in reset
  // or while the pipeline is unable to accept a new word
  always_comb begin
    w_gnt = '0;
    if (w_found && w_advance && !rst) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  assign w_xfer = |(req & w_gnt);

  // Route the winning requester's word towards stage 0
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == TAGW'(i)) begin
        w_sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves to the requester just after the one served, wrapping
  // back to zero so it never holds an index of NREQ or above
  always_comb begin
    w_ptr_next = '0;
    if (w_idx != TAGW'(NREQ - 1)) begin
      w_ptr_next = w_idx + 1'b1;
    end
  end

  // Popcount of the valid bits the stages will hold after the next shift
  always_comb begin
    w_count_next = CNTW'(w_xfer);
    for (int k = 1; k < DEPTH; k++) begin
      w_count_next = w_count_next + CNTW'(r_valid[k-1]);
    end
  end

  // Advance the round-robin pointer only on an accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_advance && w_xfer) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Shift the pipeline one stage; an idle cycle inserts a bubble at stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_tag[k]   <= '0;
      end
    end else if (w_advance) begin
      r_valid[0] <= w_xfer;
      r_data[0]  <= w_sel_data;
      r_tag[0]   <= w_idx;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
        r_tag[k]   <= r_tag[k-1];
      end
    end
  end

  // Track how many stages hold a word, in step with the shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_advance) begin
      r_inflight <= w_count_next;
    end
  end

  assign gnt       = w_gnt;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign out_tag   = r_tag[DEPTH-1];
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_shift_pipe_arbiter.sv
// tb_shift_pipe_arbiter
//   Directed bench for shift_pipe_arbiter. The main instance uses the
//   default NREQ=4, WIDTH=8, DEPTH=2 configuration; a second instance uses
//   NREQ=3, DEPTH=1 to cover the non-power-of-two wrap and the one-cycle
//   latency. The stall scenario is only built when PIPE_STALL_EN is defined.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.

module tb_shift_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  gnt;
  logic        outValid;
  logic [7:0]  outData;
  logic [1:0]  outTag;
  logic [1:0]  inflight;

  logic [2:0]  req3;
  logic [23:0] reqData3;
  logic [2:0]  gnt3;
  logic        outValid3;
  logic [7:0]  outData3;
  logic [1:0]  outTag3;
  logic [0:0]  inflight3;

`ifdef PIPE_STALL_EN
  logic        outReady;
`endif

  int checks   = 0;
  int failures = 0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  shift_pipe_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (reqData),
`ifdef PIPE_STALL_EN
    .out_ready (outReady),
`endif
    .gnt       (gnt),
    .out_valid (outValid),
    .out_data  (outData),
    .out_tag   (outTag),
    .inflight  (inflight)
  );

  shift_pipe_arbiter #(.NREQ(3), .WIDTH(8), .DEPTH(1)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req       (req3),
    .req_data  (reqData3),
`ifdef PIPE_STALL_EN
    .out_ready (outReady),
`endif
    .gnt       (gnt3),
    .out_valid (outValid3),
    .out_data  (outData3),
    .out_tag   (outTag3),
    .inflight  (inflight3)
  );

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of requests on the main instance and check it at the falling edge
  task automatic applyStimulus(input string name, input logic [3:0] reqVal,
                               input logic [3:0] expGnt, input logic expValid,
                               input logic [1:0] expTag);
    req = reqVal;
    @(negedge clk);
    checkOutput({name, " gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({name, " out_valid"}, 32'(outValid), 32'(expValid));
    if (expValid) begin
      checkOutput({name, " out_tag"}, 32'(outTag), 32'(expTag));
    end
    @(posedge clk);
    #1;
  endtask

  // Hand-computed sequence: all four requesting for 8 cycles from ptr=0,
  // then drain, then 1010 with requester 3 dropping after its first grant
  logic [3:0] seqReq   [18] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0,
                                4'hA, 4'hA, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
  logic [3:0] seqGnt   [18] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0,
                                4'h2, 4'h8, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
  logic       seqValid [18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] seqTag   [18] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                2'd0, 2'd0, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0};

  logic [2:0] gnt3Exp  [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  logic [1:0] tag3Exp  [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [7:0] data3Exp [5] = '{8'h00, 8'h10, 8'h21, 8'h32, 8'h10};

  initial begin
    rst      = 1'b1;
    req      = 4'hF;
    reqData  = 32'h4433_22A5;
    req3     = 3'b000;
    reqData3 = {8'h32, 8'h21, 8'h10};
`ifdef PIPE_STALL_EN
    outReady = 1'b1;
`endif

    // Reset state, with requests already pending
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset gnt", 32'(gnt), 32'h0);
    checkOutput("reset out_valid", 32'(outValid), 32'h0);
    checkOutput("reset out_data", 32'(outData), 32'h0);
    checkOutput("reset inflight", 32'(inflight), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word from requester 0: latency 2, inflight 1,1,0
    applyStimulus("single n", 4'h1, 4'h1, 1'b0, 2'd0);
    req = 4'h0;
    @(negedge clk);
    checkOutput("single n+1 inflight", 32'(inflight), 32'd1);
    checkOutput("single n+1 out_valid", 32'(outValid), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("single n+2 out_valid", 32'(outValid), 32'h1);
    checkOutput("single n+2 out_data", 32'(outData), 32'hA5);
    checkOutput("single n+2 out_tag", 32'(outTag), 32'h0);
    checkOutput("single n+2 inflight", 32'(inflight), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("single n+3 out_valid", 32'(outValid), 32'h0);
    checkOutput("single n+3 inflight", 32'(inflight), 32'd0);
    @(posedge clk);
    #1;

    // Bring the pointer back to 0 before the rotation sequence
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 18; c++) begin
      applyStimulus($sformatf("seq%0d", c), seqReq[c], seqGnt[c], seqValid[c], seqTag[c]);
    end

    // Fill the pipeline from requester 2 (ptr is 2 here), then reset mid-flight
    applyStimulus("fill0", 4'h4, 4'h4, 1'b0, 2'd0);
    applyStimulus("fill1", 4'h4, 4'h4, 1'b0, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst gnt", 32'(gnt), 32'h0);
    checkOutput("midrst inflight before", 32'(inflight), 32'd2);
    checkOutput("midrst out_tag before", 32'(outTag), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'h0;
    @(negedge clk);
    checkOutput("postrst out_valid", 32'(outValid), 32'h0);
    checkOutput("postrst inflight", 32'(inflight), 32'd0);
    checkOutput("postrst out_tag", 32'(outTag), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus("postrst ptr", 4'hF, 4'h1, 1'b0, 2'd0);
    applyStimulus("drain0", 4'h0, 4'h0, 1'b0, 2'd0);
    applyStimulus("drain1", 4'h0, 4'h0, 1'b1, 2'd0);

    // NREQ=3, DEPTH=1: pointer wraps 2 -> 0, latency one cycle
    for (int c = 0; c < 5; c++) begin
      req3 = (c < 4) ? 3'b111 : 3'b000;
      @(negedge clk);
      checkOutput($sformatf("n3 c%0d gnt", c), 32'(gnt3), 32'(gnt3Exp[c]));
      checkOutput($sformatf("n3 c%0d out_valid", c), 32'(outValid3), 32'(c > 0));
      if (c > 0) begin
        checkOutput($sformatf("n3 c%0d out_tag", c), 32'(outTag3), 32'(tag3Exp[c]));
        checkOutput($sformatf("n3 c%0d out_data", c), 32'(outData3), 32'(data3Exp[c]));
        checkOutput($sformatf("n3 c%0d inflight", c), 32'(inflight3), 32'd1);
      end
      @(posedge clk);
      #1;
    end

`ifdef PIPE_STALL_EN
    // Stall: word 3C waits at the output while requester 0 keeps asking
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reqData = 32'h4433_223C;
    applyStimulus("stall load", 4'h1, 4'h1, 1'b0, 2'd0);
    applyStimulus("stall gap", 4'h0, 4'h0, 1'b0, 2'd0);
    outReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req = 4'h1;
      @(negedge clk);
      checkOutput($sformatf("stall%0d gnt", c), 32'(gnt), 32'h0);
      checkOutput($sformatf("stall%0d out_valid", c), 32'(outValid), 32'h1);
      checkOutput($sformatf("stall%0d out_data", c), 32'(outData), 32'h3C);
      checkOutput($sformatf("stall%0d inflight", c), 32'(inflight), 32'd1);
      @(posedge clk);
      #1;
    end
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("stall release gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    req = 4'h0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
